sensor_scan_scheduler: RTL and testbench

SENSOR_SCAN_SCHEDULER -- requirements
Module: sensor_scan_scheduler

---
 rtl/sensor_pkg.sv | 12 +
 rtl/sensor_scan_scheduler_rr_arbiter.sv | 28 ++
 rtl/sensor_scan_scheduler.sv | 110 +++++++++++
 tb/tb_sensor_scan_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared defaults and state encoding for the sensor scan scheduler.
package sensor_pkg;
    localparam int N_CH_DEF    = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int REFRACT_DEF = 4;
    localparam int THRESH_DEF  = 128;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/sensor_scan_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    logic          found;
    int            idx;
    logic [PW-1:0] pos;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            pos = PW'(idx);
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sensor_scan_scheduler.sv
// Shares one spike encoder among N_CH sensors with per-channel
// thresholds and refractory periods.
module sensor_scan_scheduler
    import sensor_pkg::*;
#(
    parameter  int N_CH    = N_CH_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int REFRACT = REFRACT_DEF,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          req_ready,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [DATA_W-1:0]        cfg_thresh,
    output logic                     spike_valid,
    output logic [CH_W-1:0]          spike_ch,
    input  logic                     spike_ready,
    output logic [15:0]              spike_count,
    output logic                     busy
);
    state_t            state, next_state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gidx;
    logic [N_CH-1:0]   grant;
    logic [DATA_W-1:0] gdata;
    logic [DATA_W-1:0] thresh   [N_CH];
    logic [3:0]        refr_cnt [N_CH];
    logic              xfer, fire, accept;

    rr_arbiter #(.N(N_CH), .PW(CH_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready   = (state == IDLE && !rst) ? grant : '0;
    assign busy        = (state == EMIT) && !rst;
    assign spike_valid = (state == EMIT);
    assign xfer        = |(req_valid & req_ready);
    assign gdata       = req_data[gidx*DATA_W +: DATA_W];

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) gidx = CH_W'(i);
        end
    end

    always_comb begin
        next_state = state;
        fire       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer && gdata > thresh[gidx] && refr_cnt[gidx] == 4'd0) begin
                    fire       = 1'b1;
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (spike_ready) begin
                    accept     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_ch    <= '0;
            rr_ptr      <= '0;
            spike_count <= '0;
        end else begin
            if (fire) spike_ch <= gidx;
            if (xfer) begin
                rr_ptr <= (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
            end
            if (accept && spike_count != 16'hFFFF) begin
                spike_count <= spike_count + 16'd1;
            end
        end
    end

    // The threshold compare above sees the pre-write value on a shared edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                thresh[i]   <= DATA_W'(THRESH_DEF);
                refr_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (fire && gidx == CH_W'(i)) refr_cnt[i] <= 4'(REFRACT);
                else if (refr_cnt[i] != 4'd0) refr_cnt[i] <= refr_cnt[i] - 4'd1;
            end
            if (cfg_we && int'(cfg_ch) < N_CH) thresh[cfg_ch] <= cfg_thresh;
        end
    end
endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Bench for sensor_scan_scheduler: transaction-level model plus directed
// literal checks of the scheduling scenarios.
module tb_sensor_scan_scheduler;
    localparam int N  = 4;
    localparam int RF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_thresh;
    logic        spike_valid;
    logic [1:0]  spike_ch;
    logic        spike_ready;
    logic [15:0] spike_count;
    logic        busy;

    int nvec = 0;
    int nbad = 0;

    int m_thr [N];
    int m_refr[N];
    int m_rr, m_sch, m_cnt;
    bit m_pend;

    sensor_scan_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thresh(cfg_thresh),
        .spike_valid(spike_valid), .spike_ch(spike_ch),
        .spike_ready(spike_ready), .spike_count(spike_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic int chan_data(input int c);
        logic [7:0] d;
        d = req_data[c*8 +: 8];
        return int'(d);
    endfunction

    // Model: one scheduling decision per clock, computed from the rules.
    always @(posedge clk or posedge rst) begin
        int g;
        bit hit, sp;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_thr[i]  = 128;
                m_refr[i] = 0;
            end
            m_rr = 0; m_sch = 0; m_cnt = 0; m_pend = 1'b0;
        end else begin
            g   = pick();
            hit = !m_pend && g >= 0;
            sp  = hit && chan_data(g) > m_thr[g] && m_refr[g] == 0;
            for (int i = 0; i < N; i++) if (m_refr[i] > 0) m_refr[i]--;
            if (sp) m_refr[g] = RF;
            if (cfg_we) m_thr[cfg_ch] = int'(cfg_thresh);
            if (m_pend) begin
                if (spike_ready) begin
                    m_pend = 1'b0;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else if (sp) begin
                m_pend = 1'b1;
                m_sch  = g;
            end
            if (hit) m_rr = (g + 1) % N;
        end
    end

    always @(negedge clk) begin
        int g, er;
        g  = pick();
        er = (rst || m_pend || g < 0) ? 0 : (1 << g);
        chk("m_req_ready",   int'(req_ready),   er);
        chk("m_spike_valid", int'(spike_valid), int'(m_pend));
        chk("m_spike_ch",    int'(spike_ch),    m_sch);
        chk("m_spike_count", int'(spike_count), m_cnt);
        chk("m_busy",        int'(busy),        int'(m_pend && !rst));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int d);
        req_valid = 4'(1 << ch);
        req_data[ch*8 +: 8] = 8'(d);
    endtask

    logic [3:0] seq [5];

    initial begin
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; req_valid = '0; req_data = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_thresh = '0; spike_ready = 1'b0;
        step(2);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_count", int'(spike_count), 0);
        rst = 1'b0;
        step(1);

        // ch2 129 beats default threshold
        send(2, 129); #1;
        chk("ch2_grant", int'(req_ready), 4);
        step(1); req_valid = '0; #1;
        chk("ch2_spike", int'(spike_valid), 1);
        chk("ch2_ch",    int'(spike_ch), 2);
        spike_ready = 1'b1; step(1); spike_ready = 1'b0; #1;
        chk("ch2_count", int'(spike_count), 1);

        // equal to threshold: consumed, no spike
        send(0, 128); #1;
        chk("eq_grant", int'(req_ready), 1);
        step(1); req_valid = '0; #1;
        chk("eq_nospike", int'(spike_valid), 0);
        chk("eq_idle",    int'(busy), 0);

        // refractory on ch1
        send(1, 200); step(1); req_valid = '0;
        spike_ready = 1'b1; step(1); spike_ready = 1'b0;
        chk("rf_count", int'(spike_count), 2);
        step(1);
        send(1, 200); step(1); req_valid = '0; #1;
        chk("rf_drop", int'(spike_valid), 0);
        step(1);
        send(1, 200); step(1); req_valid = '0; #1;
        chk("rf_spike", int'(spike_valid), 1);
        chk("rf_ch",    int'(spike_ch), 1);

        // backpressure hold with all channels requesting
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", int'(spike_valid), 1);
            chk("bp_ch",    int'(spike_ch), 1);
            chk("bp_ready", int'(req_ready), 0);
            chk("bp_busy",  int'(busy), 1);
            step(1);
        end
        req_valid = '0;
        spike_ready = 1'b1; step(1); spike_ready = 1'b0; #1;
        chk("bp_count", int'(spike_count), 3);

        // same-edge threshold write uses old threshold
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_thresh = 8'd50;
        send(3, 100); #1;
        chk("cw_grant", int'(req_ready), 8);
        step(1); cfg_we = 1'b0; req_valid = '0; #1;
        chk("cw_old", int'(spike_valid), 0);
        send(3, 100); step(1); req_valid = '0; #1;
        chk("cw_new", int'(spike_valid), 1);
        chk("cw_ch",  int'(spike_ch), 3);
        spike_ready = 1'b1; step(1);

        // spike_ready while idle does nothing
        step(2); spike_ready = 1'b0; #1;
        chk("idle_rdy_count", int'(spike_count), 4);

        // threshold 0xFF never spikes
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_thresh = 8'hFF; step(1); cfg_we = 1'b0;
        send(0, 255); step(1); req_valid = '0; #1;
        chk("ff_nospike", int'(spike_valid), 0);

        // reset during EMIT drops the spike
        send(2, 200); step(1); req_valid = '0; #1;
        chk("re_spike", int'(spike_valid), 1);
        rst = 1'b1; #1;
        chk("re_valid", int'(spike_valid), 0);
        chk("re_count", int'(spike_count), 0);
        step(1); rst = 1'b0; step(1);

        // round-robin sweep
        req_valid = 4'hF; req_data = {4{8'd10}};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", int'(req_ready), int'(seq[k]));
            step(1);
        end
        req_valid = '0;

        // mixed traffic checked by the model only
        for (int k = 0; k < 60; k++) begin
            req_valid   = 4'($urandom_range(0, 15));
            req_data    = $urandom;
            for (int c = 0; c < N; c++) req_data[c*8 +: 8] = 8'($urandom_range(100, 170));
            spike_ready = 1'($urandom_range(0, 1));
            cfg_we      = ($urandom_range(0, 7) == 0);
            cfg_ch      = 2'($urandom_range(0, 3));
            cfg_thresh  = 8'($urandom_range(90, 170));
            step(1);
        end
        req_valid = '0; cfg_we = 1'b0; spike_ready = 1'b1;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
